// File: rtl/dot_scan_capture.sv
// Receive side of the 16x16 dot-matrix column-scan link. Rebuilds frames from the
// column stream in a shadow buffer, commits in-order frames to a readable frame
// buffer, and reports completion, change, stability and sequencing errors.
module dot_scan_capture #(
  parameter int unsigned STABLE_FRAMES = 4  // 1..255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        scan_valid_i,
  input  logic [3:0]  scan_col_i,
  input  logic [15:0] scan_row_i,
  input  logic [3:0]  rd_col_i,
  output logic [15:0] rd_data_o,
  output logic        frame_done_o,
  output logic        frame_changed_o,
  output logic        glyph_stable_o,
  output logic        seq_err_o,
  output logic [7:0]  err_cnt_o,
  output logic [7:0]  frame_cnt_o
);

  localparam logic [0:0] StHunt = 1'b0;
  localparam logic [0:0] StCap  = 1'b1;

  localparam logic [7:0] StableMax = 8'(STABLE_FRAMES);

  logic [0:0]  state_q, state_d;
  logic [3:0]  exp_col_q, exp_col_d;
  logic [15:0] shadow_q [16];
  logic [15:0] frame_buf_q [16];
  logic        commit_q, commit_d;
  logic [7:0]  stable_q, stable_d;
  logic [15:0] rd_data_q;
  logic        frame_done_q, frame_changed_q, glyph_stable_q, seq_err_q;
  logic [7:0]  err_cnt_q, frame_cnt_q;

  logic        wr_en;
  logic        bad_col;
  logic        changed;

  // Column sequencing: decide whether this beat is stored, completes a frame, or is an error.
  always_comb begin
    state_d   = state_q;
    exp_col_d = exp_col_q;
    wr_en     = 1'b0;
    bad_col   = 1'b0;
    commit_d  = 1'b0;
    if (scan_valid_i) begin
      unique case (state_q)
        StHunt: begin
          if (scan_col_i == 4'd0) begin
            wr_en     = 1'b1;
            exp_col_d = 4'd1;
            state_d   = StCap;
          end
        end
        StCap: begin
          if (scan_col_i == exp_col_q) begin
            wr_en = 1'b1;
            if (exp_col_q == 4'd15) begin
              commit_d  = 1'b1;
              exp_col_d = 4'd0;
              state_d   = StHunt;
            end else begin
              exp_col_d = exp_col_q + 4'd1;
            end
          end else begin
            bad_col = 1'b1;
            // A stray column 0 is treated as the start of a fresh frame.
            if (scan_col_i == 4'd0) begin
              wr_en     = 1'b1;
              exp_col_d = 4'd1;
            end else begin
              exp_col_d = 4'd0;
              state_d   = StHunt;
            end
          end
        end
        default: begin
          exp_col_d = 4'd0;
          state_d   = StHunt;
        end
      endcase
    end
  end

  // Compare the pending frame with what is currently committed, and derive the stable run.
  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (shadow_q[i] != frame_buf_q[i]) changed = 1'b1;
    end
    if (changed) begin
      stable_d = 8'd1;
    end else if (stable_q < StableMax) begin
      stable_d = stable_q + 8'd1;
    end else begin
      stable_d = stable_q;
    end
  end

  // Capture, commit and status registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StHunt;
      exp_col_q       <= 4'd0;
      commit_q        <= 1'b0;
      stable_q        <= 8'd0;
      rd_data_q       <= 16'd0;
      frame_done_q    <= 1'b0;
      frame_changed_q <= 1'b0;
      glyph_stable_q  <= 1'b0;
      seq_err_q       <= 1'b0;
      err_cnt_q       <= 8'd0;
      frame_cnt_q     <= 8'd0;
      for (int i = 0; i < 16; i++) begin
        shadow_q[i]    <= 16'd0;
        frame_buf_q[i] <= 16'd0;
      end
    end else begin
      state_q   <= state_d;
      exp_col_q <= exp_col_d;
      commit_q  <= commit_d;
      // Read before the commit lands, so a same-cycle read sees the old frame.
      rd_data_q <= frame_buf_q[rd_col_i];
      if (wr_en) shadow_q[scan_col_i] <= scan_row_i;
      seq_err_q <= bad_col;
      if (bad_col && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
      frame_done_q    <= commit_q;
      frame_changed_q <= commit_q & changed;
      if (commit_q) begin
        for (int i = 0; i < 16; i++) frame_buf_q[i] <= shadow_q[i];
        frame_cnt_q    <= frame_cnt_q + 8'd1;
        stable_q       <= stable_d;
        glyph_stable_q <= (stable_d >= StableMax);
      end
    end
  end

  assign rd_data_o       = rd_data_q;
  assign frame_done_o    = frame_done_q;
  assign frame_changed_o = frame_changed_q;
  assign glyph_stable_o  = glyph_stable_q;
  assign seq_err_o       = seq_err_q;
  assign err_cnt_o       = err_cnt_q;
  assign frame_cnt_o     = frame_cnt_q;

endmodule

// File: tb/tb_dot_scan_capture.sv
// Bench for dot_scan_capture: directed scenarios plus randomized column streams,
// checked every cycle against a frame-level reference model.
module tb_dot_scan_capture;

  localparam int unsigned StableFrames = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        scan_valid_i;
  logic [3:0]  scan_col_i;
  logic [15:0] scan_row_i;
  logic [3:0]  rd_col_i;
  logic [15:0] rd_data_o;
  logic        frame_done_o, frame_changed_o, glyph_stable_o, seq_err_o;
  logic [7:0]  err_cnt_o, frame_cnt_o;

  always #5 clk_i = ~clk_i;

  dot_scan_capture #(.STABLE_FRAMES(StableFrames)) u_dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .scan_valid_i   (scan_valid_i),
    .scan_col_i     (scan_col_i),
    .scan_row_i     (scan_row_i),
    .rd_col_i       (rd_col_i),
    .rd_data_o      (rd_data_o),
    .frame_done_o   (frame_done_o),
    .frame_changed_o(frame_changed_o),
    .glyph_stable_o (glyph_stable_o),
    .seq_err_o      (seq_err_o),
    .err_cnt_o      (err_cnt_o),
    .frame_cnt_o    (frame_cnt_o)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: frames are built from in-order column runs; a complete
  // run becomes visible one edge after its last column.
  logic [15:0] m_fb [16];
  logic [15:0] m_part [16];
  logic [15:0] m_pend [16];
  bit          m_has_pend;
  int          m_have;    // columns gathered in the current run, 0 = waiting for col 0
  int          m_run;     // consecutive identical commits
  int          m_errs;
  int          m_fcnt;
  logic [15:0] e_rd;
  bit          e_done, e_chg, e_seq;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) m_fb[i] = 16'd0;
    m_has_pend = 0;
    m_have = 0;
    m_run = 0;
    m_errs = 0;
    m_fcnt = 0;
    e_rd = 16'd0;
    e_done = 0;
    e_chg = 0;
    e_seq = 0;
  endfunction

  function automatic void model_edge(input logic v, input logic [3:0] c, input logic [15:0] r,
                                     input logic [3:0] rc);
    if (!rst_ni) begin
      m_reset();
      return;
    end
    e_rd = m_fb[rc];
    e_done = 0;
    e_chg = 0;
    e_seq = 0;
    if (m_has_pend) begin
      e_done = 1;
      for (int i = 0; i < 16; i++) if (m_pend[i] != m_fb[i]) e_chg = 1;
      for (int i = 0; i < 16; i++) m_fb[i] = m_pend[i];
      m_fcnt = (m_fcnt + 1) % 256;
      m_run = e_chg ? 1 : m_run + 1;
      m_has_pend = 0;
    end
    if (v) begin
      if (m_have == 0) begin
        if (c == 4'd0) begin
          m_part[0] = r;
          m_have = 1;
        end
      end else if (int'(c) == m_have) begin
        m_part[c] = r;
        m_have++;
        if (m_have == 16) begin
          for (int i = 0; i < 16; i++) m_pend[i] = m_part[i];
          m_has_pend = 1;
          m_have = 0;
        end
      end else begin
        e_seq = 1;
        if (m_errs < 255) m_errs++;
        if (c == 4'd0) begin
          m_part[0] = r;
          m_have = 1;
        end else begin
          m_have = 0;
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("rd_data", 32'(rd_data_o), 32'(e_rd));
    check("frame_done", 32'(frame_done_o), 32'(e_done));
    check("frame_changed", 32'(frame_changed_o), 32'(e_chg));
    check("glyph_stable", 32'(glyph_stable_o), 32'(m_run >= int'(StableFrames)));
    check("seq_err", 32'(seq_err_o), 32'(e_seq));
    check("err_cnt", 32'(err_cnt_o), 32'(m_errs));
    check("frame_cnt", 32'(frame_cnt_o), 32'(m_fcnt));
  endtask

  // One clock: drive at the falling edge, model the rising edge, sample 1 time unit later.
  task automatic cycle(input logic v, input logic [3:0] c, input logic [15:0] r,
                       input logic [3:0] rc);
    scan_valid_i = v;
    scan_col_i   = c;
    scan_row_i   = r;
    rd_col_i     = rc;
    @(posedge clk_i);
    model_edge(v, c, r, rc);
    #1;
    compare_all();
    @(negedge clk_i);
  endtask

  task automatic idle(input logic [3:0] rc);
    cycle(1'b0, 4'($urandom_range(15)), 16'($urandom), rc);
  endtask

  logic [15:0] frm [16];

  task automatic send_cols(input int lo, input int hi);
    for (int c = lo; c <= hi; c++) begin
      if ($urandom_range(3) == 0) idle(4'($urandom_range(15)));
      cycle(1'b1, 4'(c), frm[c], 4'($urandom_range(15)));
    end
  endtask

  task automatic rand_frame();
    int pick;
    pick = int'($urandom_range(3));
    for (int i = 0; i < 16; i++) frm[i] = (pick == 0) ? 16'($urandom) : 16'((pick * 16'h1111) ^ i);
  endtask

  task automatic mid_reset();
    rst_ni = 1'b0;
    #1;
    m_reset();
    compare_all();
    cycle(1'b1, 4'd0, 16'hFFFF, 4'($urandom_range(15)));
    cycle(1'b0, 4'd0, 16'h0, 4'd0);
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    scan_valid_i = 1'b0;
    scan_col_i = 4'd0;
    scan_row_i = 16'd0;
    rd_col_i = 4'd0;
    m_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    compare_all();
    rst_ni = 1'b1;

    // Single column lit, then read it back.
    for (int i = 0; i < 16; i++) frm[i] = 16'd0;
    frm[3] = 16'h1FFF;
    send_cols(0, 15);
    idle(4'd3);
    idle(4'd3);
    check("t1_rd_col3", 32'(rd_data_o), 32'h1FFF);
    check("t1_frame_cnt", 32'(frame_cnt_o), 32'd1);

    // Same frame repeated until stable.
    for (int k = 0; k < 4; k++) send_cols(0, 15);
    idle(4'd0);
    check("t2_stable", 32'(glyph_stable_o), 32'd1);

    // Skipped column, then recovery.
    send_cols(0, 5);
    cycle(1'b1, 4'd9, 16'hAAAA, 4'd0);
    send_cols(0, 15);

    // Restart at col 0 mid-frame overwrites stale columns.
    rand_frame();
    send_cols(0, 7);
    rand_frame();
    send_cols(0, 15);

    // Commit cycle read of col 15 returns the old value.
    frm[15] = ~frm[15];
    send_cols(0, 15);
    idle(4'd15);
    idle(4'd15);

    // Start mid-stream.
    rand_frame();
    send_cols(6, 15);
    send_cols(0, 15);
    idle(4'd0);

    // Reset in the middle of frame 2.
    rand_frame();
    send_cols(0, 15);
    send_cols(0, 10);
    mid_reset();
    check("t6_err_cnt_cleared", 32'(err_cnt_o), 32'd0);
    rand_frame();
    send_cols(0, 15);
    idle(4'd0);
    check("t6_frame_cnt", 32'(frame_cnt_o), 32'd1);

    // Randomized column stream with gaps, wrong columns and restarts.
    begin
      int nxt = 0;
      for (int n = 0; n < 3000; n++) begin
        int sel = int'($urandom_range(9));
        if (sel < 6) begin
          cycle(1'b1, 4'(nxt), (sel == 0) ? 16'($urandom) : 16'(16'h0F0F ^ nxt),
                4'($urandom_range(15)));
          nxt = (nxt + 1) % 16;
        end else if (sel < 8) begin
          idle(4'($urandom_range(15)));
        end else begin
          nxt = int'($urandom_range(15));
          cycle(1'b1, 4'(nxt), 16'($urandom), 4'($urandom_range(15)));
          nxt = (nxt + 1) % 16;
        end
      end
    end

    // Drive the error counter into saturation.
    for (int k = 0; k < 260; k++) begin
      cycle(1'b1, 4'd0, 16'h1234, 4'd0);
      cycle(1'b1, 4'd5, 16'h5678, 4'd0);
    end
    check("err_cnt_sat", 32'(err_cnt_o), 32'd255);

    // Enough commits to wrap the frame counter.
    mid_reset();
    for (int k = 0; k < 256; k++) begin
      rand_frame();
      send_cols(0, 15);
    end
    idle(4'd0);
    check("frame_cnt_wrap", 32'(frame_cnt_o), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
